// File: rtl/qpu_exu_moitf.sv
// Outstanding-instruction track FIFO for long-pipe (measure/FMR) QPU ops.
// Holds destination register and qubit list per in-flight op and raises dispatch hazard flags.
module qpu_exu_moitf #(
    parameter int DEPTH     = 4,
    parameter int QUBIT_NUM = 8,
    parameter int RFIDX_W   = 5,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 dis_ena,
    output logic                 dis_ready,
    input  logic                 dis_rdwen,
    input  logic [RFIDX_W-1:0]   dis_rdidx,
    input  logic [QUBIT_NUM-1:0] dis_qubitlist,

    input  logic                 chk_rs1en,
    input  logic                 chk_rs2en,
    input  logic                 chk_rdwen,
    input  logic                 chk_qfren,
    input  logic [RFIDX_W-1:0]   chk_rs1idx,
    input  logic [RFIDX_W-1:0]   chk_rs2idx,
    input  logic [RFIDX_W-1:0]   chk_rdidx,
    input  logic [QUBIT_NUM-1:0] chk_qubitlist,
    output logic                 oitfrd_match_disprs1,
    output logic                 oitfrd_match_disprs2,
    output logic                 oitfrd_match_disprd,
    output logic                 oitfqf_match_dispql,

    input  logic                 ret_ena,
    output logic                 ret_rdwen,
    output logic [RFIDX_W-1:0]   ret_rdidx,
    output logic [QUBIT_NUM-1:0] ret_qubitlist,

    input  logic                 flush,
    output logic                 oitf_empty,
    output logic [PTR_W:0]       oitf_count
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0]     ent_vld;
    logic [DEPTH-1:0]     ent_rdwen;
    logic [RFIDX_W-1:0]   ent_rdidx [DEPTH];
    logic [QUBIT_NUM-1:0] ent_ql    [DEPTH];

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wflag;
    logic             rflag;

    logic full;
    logic do_alloc;
    logic do_retire;

    // Handshake: an allocation transfers on a rising edge where dis_ena && dis_ready;
    // dis_ready depends only on registered state, so a retire in the same cycle
    // never frees space for that cycle's allocation. A retire transfers when
    // ret_ena && !oitf_empty. flush overrides both.
    assign full       = (wptr == rptr) && (wflag != rflag);
    assign oitf_empty = (wptr == rptr) && (wflag == rflag);
    assign dis_ready  = !full;
    assign do_alloc   = dis_ena && !full;
    assign do_retire  = ret_ena && !oitf_empty;

    assign oitf_count = ({1'b0, wptr} - {1'b0, rptr}) + ((wflag != rflag) ? CNT_DEPTH : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld   <= '0;
            ent_rdwen <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rdidx[i] <= '0;
                ent_ql[i]    <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            wflag <= 1'b0;
            rflag <= 1'b0;
        end else if (flush) begin
            ent_vld <= '0;
            wptr    <= '0;
            rptr    <= '0;
            wflag   <= 1'b0;
            rflag   <= 1'b0;
        end else begin
            // Alloc and retire never hit the same slot: that needs wptr==rptr,
            // which is either full (no alloc) or empty (no retire).
            if (do_alloc) begin
                ent_vld[wptr]   <= 1'b1;
                ent_rdwen[wptr] <= dis_rdwen;
                ent_rdidx[wptr] <= dis_rdidx;
                ent_ql[wptr]    <= dis_qubitlist;
                if (wptr == PTR_LAST) begin
                    wptr  <= '0;
                    wflag <= !wflag;
                end else begin
                    wptr <= wptr + 1'b1;
                end
            end
            if (do_retire) begin
                ent_vld[rptr] <= 1'b0;
                if (rptr == PTR_LAST) begin
                    rptr  <= '0;
                    rflag <= !rflag;
                end else begin
                    rptr <= rptr + 1'b1;
                end
            end
        end
    end

    // Hazard flags look only at registered entries; a retiring head still matches.
    always_comb begin
        logic                 m_rs1;
        logic                 m_rs2;
        logic                 m_rd;
        logic [QUBIT_NUM-1:0] ql_or;
        m_rs1 = 1'b0;
        m_rs2 = 1'b0;
        m_rd  = 1'b0;
        ql_or = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                ql_or = ql_or | ent_ql[i];
                if (ent_rdwen[i]) begin
                    if (ent_rdidx[i] == chk_rs1idx) m_rs1 = 1'b1;
                    if (ent_rdidx[i] == chk_rs2idx) m_rs2 = 1'b1;
                    if (ent_rdidx[i] == chk_rdidx)  m_rd  = 1'b1;
                end
            end
        end
        oitfrd_match_disprs1 = chk_rs1en & m_rs1;
        oitfrd_match_disprs2 = chk_rs2en & m_rs2;
        oitfrd_match_disprd  = chk_rdwen & m_rd;
        oitfqf_match_dispql  = chk_qfren & (|(chk_qubitlist & ql_or));
    end

    // The head slot is valid exactly when the FIFO is non-empty.
    assign ret_rdwen     = ent_vld[rptr] & ent_rdwen[rptr];
    assign ret_rdidx     = ent_vld[rptr] ? ent_rdidx[rptr] : '0;
    assign ret_qubitlist = ent_vld[rptr] ? ent_ql[rptr]    : '0;

endmodule
